// File: rtl/uart_pkg.sv
// uart_pkg: UART types and constants shared by the receiver and transmitter
package uart_pkg;
  localparam int DEF_OVERSAMPLE = 16;
  localparam logic [2:0] LAST_BIT = 3'd7;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, sample strobe and received-byte signals of the UART receiver
interface uart_rx_if;
  logic       stb_sample;
  logic       data_in;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  modport master (input stb_sample, data_in, output data_out, rx_valid, rx_busy, frame_err);
  modport slave (output stb_sample, data_in, input data_out, rx_valid, rx_busy, frame_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with false-start, framing-error and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input logic clk,
  input logic rst_n,
  uart_rx_if.master bus
);
  localparam int W = $clog2(OVERSAMPLE);
  localparam logic [W-1:0] MID = W'(OVERSAMPLE / 2 - 1);
  localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);
  rx_state_e state_q, state_d;
  logic [W-1:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rx_s, end_hit;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (bus.data_in),
    .q_o  (rx_s)
  );
  assign end_hit = (samp_q == LAST);
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (bus.stb_sample) begin
      unique case (state_q)
        IDLE: begin
          samp_d  = rx_s ? '0 : W'(1);
          state_d = rx_s ? IDLE : START;
        end
        START: begin
          samp_d = (samp_q == MID) ? '0 : samp_q + W'(1);
          if (samp_q == MID) begin
            state_d = rx_s ? IDLE : DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          samp_d = end_hit ? '0 : samp_q + W'(1);
          if (end_hit) begin
            shift_d = {rx_s, shift_q[7:1]};
            state_d = (bit_q == LAST_BIT) ? STOP : DATA;
            bit_d   = (bit_q == LAST_BIT) ? bit_q : bit_q + 3'd1;
          end
        end
        STOP: begin
          samp_d = end_hit ? '0 : samp_q + W'(1);
          if (end_hit) begin
            state_d = rx_s ? IDLE : BREAK;
            data_d  = rx_s ? shift_q : data_q;
            valid_d = rx_s;
            ferr_d  = !rx_s;
          end
        end
        BREAK: begin
          samp_d  = '0;
          state_d = rx_s ? IDLE : BREAK;
        end
        default: begin
          samp_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  assign bus.data_out  = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy   = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
# uart_rx

UART 8N1 receiver and the receive-side counterpart of the project's UART transmitter. It accepts an asynchronous serial line, synchronises it into the `clk` domain and oversamples it against an external strobe. Each frame is delivered as one byte with a single-cycle valid pulse. Framing errors and false starts are flagged. The block sits between the board RX pin and whatever consumes bytes, for example the microprogram I/O path.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: sample strobes per bit period; must be even and at least 4.

Ports:
- `clk` input, 1 bit: single system clock; everything is synchronous to its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `stb_sample` input, 1 bit: oversample strobe, one `clk`-wide pulse at `OVERSAMPLE` × baud rate.
- `data_in` input, 1 bit: raw serial line, asynchronous; idle level is high.
- `data_out` output, 8 bits: last correctly received byte, held until the next good frame.
- `rx_valid` output, 1 bit: one-cycle pulse when `data_out` updates.
- `rx_busy` output, 1 bit: high in every state except IDLE.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit samples low.

## Operation
- Synchroniser:
  - `data_in` passes through 2 flops, both reset to 1.
  - All logic uses the synchronised value `rx_s`.
- Counters:
  - `samp_cnt` is `$clog2(OVERSAMPLE)` bits wide and advances only on `stb_sample`.
  - `bit_idx` is 3 bits, covering indices 0–7.
- IDLE:
  - `samp_cnt` is held at 0.
  - On a `stb_sample` with `rx_s == 0`, go to START with `samp_cnt = 1`.
- START:
  - On each `stb_sample`, increment `samp_cnt`.
  - When `samp_cnt` reaches `OVERSAMPLE/2 - 1` (this is the mid-bit sample):
    - If `rx_s == 1`, treat it as a false start and return to IDLE with no outputs pulsed.
    - Otherwise clear `samp_cnt` and `bit_idx`, then go to DATA.
- DATA:
  - On the strobe where `samp_cnt == OVERSAMPLE - 1`:
    - Shift `rx_s` into the shift register LSB first (bit 0 is received first).
    - Clear `samp_cnt`.
  - After bit 7 is captured, go to STOP; otherwise increment `bit_idx`.
- STOP:
  - On the strobe where `samp_cnt == OVERSAMPLE - 1`, sample `rx_s`.
  - If it is 1:
    - Load `data_out` from the shift register.
    - Pulse `rx_valid`.
    - Go to IDLE.
  - If it is 0:
    - Pulse `frame_err` and leave `data_out` unchanged.
    - Go to BREAK.
- BREAK:
  - Wait for `rx_s == 1` on a `stb_sample`, then go to IDLE.
  - A held-low line therefore never produces a frame.
- `rx_valid` and `frame_err` are mutually exclusive and are never both high.
- Counter widths wrap naturally. No compare may rely on a wrap past `OVERSAMPLE - 1`, because every count is cleared explicitly.

## Timing
- Reset values:
  - `data_out` = 0x00.
  - `rx_valid` = 0, `frame_err` = 0, `rx_busy` = 0.
  - State = IDLE.
  - Synchroniser flops = 1.
- Input latency: 2 `clk` from a `data_in` edge to `rx_s`.
- Start detection: happens on the first `stb_sample` after `rx_s` falls, so resolution is one sample period.
- Output latency: `rx_valid` and `frame_err` register on the `clk` edge that consumes the stop-bit strobe, and are high for exactly 1 cycle.
- Back-to-back frames:
  - The stop-bit sample falls at mid-stop, and the block is in IDLE at the next strobe.
  - A start bit that immediately follows a stop bit is therefore caught.
- Back-pressure: there is none. The consumer must take `data_out` before the next `rx_valid`, which is at least 10 bit periods later.
- Reset mid-frame: `rst_n` low forces IDLE asynchronously and clears all outputs. The partial byte is discarded.
- `stb_sample` is ignored in any cycle where `rst_n` is low.

## Structure
- `uart_pkg`:
  - Receiver state enum: IDLE, START, DATA, STOP, BREAK.
  - `LAST_BIT = 3'd7`.
  - Default `OVERSAMPLE`.
  - The transmitter will share this package.
- Sub-module `sync_2ff`: the generic two-flop synchroniser with a reset value parameter. It is reused for other async inputs.
- Implementation size: one FSM `always_ff` plus an `always_comb` next-state block, roughly 150–200 lines.

## Test plan
All scenarios use `OVERSAMPLE = 16` and `stb_sample` every 4 `clk`.
- Good frame: drive 0xA5 as 8N1 → one `rx_valid` pulse, `data_out = 0xA5`, `frame_err` never high, `rx_busy` high from the first strobe after the start bit until the stop sample.
- False start: pulse the line low for 5 sample periods, then high → back in IDLE after the mid-start sample, no `rx_valid`, no `frame_err`.
- Framing error then break:
  - Send 0x3C with its stop bit low and hold the line low for 30 bit periods → `frame_err` pulses once, `data_out` keeps its previous value 0xA5, `rx_busy` stays high (BREAK).
  - Release the line, then send 0x11 → `rx_valid` pulses, `data_out = 0x11`.
- Back-to-back: send 0x00 then 0xFF with no idle gap, and repeat with a ±3% baud skew → two `rx_valid` pulses with `data_out` 0x00 then 0xFF.
- Reset mid-frame:
  - Assert `rst_n` low during bit 4 of 0x5A → outputs go to reset values immediately, asynchronously.
  - Release reset, then send 0x81 → `data_out = 0x81`, no spurious pulse from the aborted frame.
